cpld_uart_ctrl: RTL and testbench
=================================

Name: cpld_uart_ctrl

Overview:
- Memory-mapped responder for the CPLD serial port. The CPU data-memory port is the initiator; this block answers at two fixed addresses.
- Drives the uart_rdn/uart_wrn strobes and handshakes on uart_dataready/uart_tbre/uart_tsre.
- Shares base_ram_data[7:0] with BaseRAM. The top level uses uart_sel_o to force base_ram_ce_n high and to steer the shared bus tri-state.
- Replaces the current tie-off of uart_rdn/uart_wrn to 1.

Parameters:
- ADDR_DATA, 32'hBFD003F8, data register address (read = RX byte, write = TX byte)
- ADDR_STAT, 32'hBFD003FC, status register address (read-only)
- SETUP_CYCLES, 1, cycles data is driven before uart_wrn falls
- PULSE_CYCLES, 3, low width of uart_rdn/uart_wrn in clk cycles
- GUARD_CYCLES, 3, wait after uart_wrn rises before sampling tbre (covers synchroniser latency)

Ports:
- clk  in  1  system clock (clk_50M domain)
- rst  in  1  synchronous active-high reset
- ce_i  in  1  CPU data-bus request
- we_i  in  1  1 = write
- addr_i  in  32  byte address
- data_i  in  32  write data; only [7:0] is used
- sel_i  in  4  byte enables; ignored
- data_o  out  32  read data
- stall_o  out  1  hold the CPU pipeline
- uart_sel_o  out  1  UART owns the shared bus; top disables BaseRAM
- uart_data_i  in  8  sampled base_ram_data[7:0]
- uart_data_o  out  8  value to drive on base_ram_data[7:0]
- uart_data_oe  out  1  tri-state enable for uart_data_o
- uart_rdn  out  1  CPLD read strobe, active low
- uart_wrn  out  1  CPLD write strobe, active low
- uart_dataready  in  1  asynchronous input from CPLD
- uart_tbre  in  1  asynchronous input from CPLD
- uart_tsre  in  1  asynchronous input from CPLD

Behaviour:
- All state changes on the rising edge of clk.
- Reset values: uart_rdn=1, uart_wrn=1, uart_data_oe=0, uart_data_o=0, data_o=0, stall_o=0, uart_sel_o=0, FSM=IDLE, all counters 0, synchroniser flops 0.
- Inputs dataready, tbre and tsre each pass through a 2-flop synchroniser (_s suffix). Only the _s values are used.
- Hit conditions:
  - hit_data = ce_i && addr_i==ADDR_DATA
  - hit_stat = ce_i && addr_i==ADDR_STAT
- Status read (hit_stat && !we_i):
  - Combinational, no stall.
  - data_o = {30'b0, dataready_s, tbre_s && tsre_s}. Bit0 = TX ready, bit1 = RX available.
- Status write: ignored, no stall, no strobes.
- stall_o is combinational: it is 1 in the IDLE cycle where hit_data is seen, and in every non-IDLE state except DONE. It is 0 in DONE.
- uart_sel_o = (state != IDLE) || hit_data.
- FSM states: IDLE, RD_LOW, WR_SETUP, WR_LOW, WR_GUARD, WR_TBRE, WR_TSRE, DONE.
- IDLE:
  - On hit_data && !we_i: go to RD_LOW; uart_rdn <= 0; cnt <= PULSE_CYCLES-1.
  - On hit_data && we_i: go to WR_SETUP; latch data_i[7:0] into uart_data_o; uart_data_oe <= 1; cnt <= SETUP_CYCLES-1.
- RD_LOW:
  - Holds uart_rdn low for PULSE_CYCLES cycles.
  - In the last low cycle (cnt==0): data_o <= {24'b0, uart_data_i}; uart_rdn <= 1; go to DONE.
  - A read is performed even if dataready_s=0. Software polls status first.
- WR_SETUP:
  - uart_wrn stays 1 for SETUP_CYCLES cycles.
  - Then uart_wrn <= 0 and go to WR_LOW.
- WR_LOW:
  - Holds uart_wrn low for PULSE_CYCLES cycles.
  - Then uart_wrn <= 1, go to WR_GUARD, cnt <= GUARD_CYCLES-1.
  - uart_data_oe stays 1 through the first WR_GUARD cycle (one-cycle hold), then goes 0.
- WR_GUARD: count down, then go to WR_TBRE.
- WR_TBRE: wait until tbre_s=1, then go to WR_TSRE.
- WR_TSRE: wait until tsre_s=1, then go to DONE. There is no timeout.
- DONE:
  - One cycle. stall_o=0; data_o is valid for reads.
  - Go to IDLE. The new request is sampled the following cycle.
- Latency:
  - Data read: PULSE_CYCLES+1 stalled cycles; DONE follows.
  - Data write: SETUP+PULSE+GUARD cycles plus the tbre/tsre wait.
- ce_i falling mid-operation does not abort; the transaction completes.
- Reset mid-operation: next state is IDLE with strobes deasserted and oe=0 in the same edge. A half-finished CPLD write is abandoned.
- uart_rdn and uart_wrn are never low simultaneously. uart_data_oe is never 1 while uart_rdn=0.

Decomposition:
- Shared package (defines.vh): the UART address constants and the FSM state encodings (3-bit localparams).
- One natural sub-module: sync2 (2-flop synchroniser, 1-bit, parameterless), instantiated three times.

Test Plan:
- Reset: hold rst 2 cycles mid-write (state WR_LOW) -> next cycle uart_wrn=1, uart_data_oe=0, stall_o=0, state IDLE.
- Status read: dataready=1, tbre=1, tsre=1, read 0xBFD003FC after sync settles -> data_o=32'h3, stall_o=0. With dataready=0, tbre=0 -> data_o=32'h0.
- Data read: CPLD model drives 8'h5A, read 0xBFD003F8 -> uart_rdn low exactly 3 cycles, stall_o high 4 cycles, DONE cycle data_o=32'h0000005A, uart_data_oe stays 0.
- Data write: write 32'hFFFFFF41 -> uart_data_o=8'h41 with oe 1 cycle before uart_wrn falls, wrn low 3 cycles, oe held 1 cycle after. Model drops tbre/tsre then raises them after 20/40 cycles -> stall_o clears only after tsre_s=1.
- Non-hit and sel: ce_i=1 at addr 0x80000000 -> uart_sel_o=0, no strobes. Write with sel_i=4'b0001 behaves identically to sel_i=4'b1111.
- Back-to-back: write followed immediately by read -> read starts after DONE+IDLE, no strobe overlap, the rdn/wrn mutual-exclusion assertion holds throughout.

Source files
------------

// File: rtl/cpld_uart_ctrl_pkg.sv
// cpld_uart_ctrl_pkg: UART register addresses, FSM state codes and status-word helper
package cpld_uart_ctrl_pkg;
  localparam logic [31:0] UART_ADDR_DATA = 32'hBFD003F8;
  localparam logic [31:0] UART_ADDR_STAT = 32'hBFD003FC;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_LOW   = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_LOW   = 3'd3;
  localparam logic [2:0] S_WR_GUARD = 3'd4;
  localparam logic [2:0] S_WR_TBRE  = 3'd5;
  localparam logic [2:0] S_WR_TSRE  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;
  function automatic logic [31:0] stat_word(input logic rx_avail, input logic tx_ready);
    return {30'b0, rx_avail, tx_ready};
  endfunction
endpackage

// File: rtl/cpld_uart_ctrl_sync2.sv
// cpld_uart_ctrl_sync2: 2-flop synchroniser for one asynchronous CPLD flag
// clk/rst: clock, sync active-high reset; d_i: async input; q_o: synchronised output
module cpld_uart_ctrl_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk)
    if (rst) {q_o, meta_q} <= 2'b00;
    else {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/cpld_uart_ctrl.sv
// cpld_uart_ctrl: memory-mapped CPLD UART responder driving uart_rdn/uart_wrn on the shared BaseRAM byte lane
// CPU side: ce_i/we_i/addr_i/data_i/sel_i in, data_o/stall_o out; uart_sel_o claims the shared bus
// CPLD side: uart_data_i/uart_data_o/uart_data_oe byte lane, uart_rdn/uart_wrn strobes, async dataready/tbre/tsre
module cpld_uart_ctrl
  import cpld_uart_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_DATA = UART_ADDR_DATA,
  parameter logic [31:0] ADDR_STAT = UART_ADDR_STAT,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 3,
  parameter int GUARD_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        uart_sel_o,
  input  logic [7:0]  uart_data_i,
  output logic [7:0]  uart_data_o,
  output logic        uart_data_oe,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_dataready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);
  logic dataready_s, tbre_s, tsre_s;
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d, tx_q, tx_d;
  logic [31:0] rd_q, rd_d;
  logic rdn_q, rdn_d, wrn_q, wrn_d, oe_q, oe_d;
  logic hit_data, hit_stat, cnt_z;
  logic unused;
  cpld_uart_ctrl_sync2 u_sync_dr (.clk(clk), .rst(rst), .d_i(uart_dataready), .q_o(dataready_s));
  cpld_uart_ctrl_sync2 u_sync_tbre (.clk(clk), .rst(rst), .d_i(uart_tbre), .q_o(tbre_s));
  cpld_uart_ctrl_sync2 u_sync_tsre (.clk(clk), .rst(rst), .d_i(uart_tsre), .q_o(tsre_s));
  assign unused = ^{sel_i, data_i[31:8]};
  assign hit_data = ce_i && addr_i == ADDR_DATA;
  assign hit_stat = ce_i && addr_i == ADDR_STAT;
  assign cnt_z = cnt_q == 8'd0;
  assign stall_o = (state_q == S_IDLE) ? hit_data : state_q != S_DONE;
  assign uart_sel_o = state_q != S_IDLE || hit_data;
  assign data_o = (hit_stat && !we_i) ? stat_word(dataready_s, tbre_s && tsre_s) : rd_q;
  assign uart_data_o = tx_q;
  assign uart_data_oe = oe_q;
  assign uart_rdn = rdn_q;
  assign uart_wrn = wrn_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - {7'd0, !cnt_z};
    tx_d = tx_q;
    rd_d = rd_q;
    rdn_d = rdn_q;
    wrn_d = wrn_q;
    oe_d = oe_q;
    case (state_q)
      S_IDLE:
        if (hit_data && we_i) begin
          state_d = S_WR_SETUP;
          tx_d = data_i[7:0];
          oe_d = 1'b1;
          cnt_d = 8'(SETUP_CYCLES - 1);
        end else if (hit_data) begin
          state_d = S_RD_LOW;
          rdn_d = 1'b0;
          cnt_d = 8'(PULSE_CYCLES - 1);
        end
      S_RD_LOW:
        if (cnt_z) begin
          rd_d = {24'b0, uart_data_i};
          rdn_d = 1'b1;
          state_d = S_DONE;
        end
      S_WR_SETUP:
        if (cnt_z) begin
          wrn_d = 1'b0;
          state_d = S_WR_LOW;
          cnt_d = 8'(PULSE_CYCLES - 1);
        end
      S_WR_LOW:
        if (cnt_z) begin
          wrn_d = 1'b1;
          state_d = S_WR_GUARD;
          cnt_d = 8'(GUARD_CYCLES - 1);
        end
      // Data stays driven for the first guard cycle as hold time after wrn rises.
      S_WR_GUARD: begin
        oe_d = 1'b0;
        if (cnt_z) state_d = S_WR_TBRE;
      end
      S_WR_TBRE: state_d = tbre_s ? S_WR_TSRE : S_WR_TBRE;
      S_WR_TSRE: state_d = tsre_s ? S_DONE : S_WR_TSRE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      tx_q <= '0;
      rd_q <= '0;
      rdn_q <= 1'b1;
      wrn_q <= 1'b1;
      oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tx_q <= tx_d;
      rd_q <= rd_d;
      rdn_q <= rdn_d;
      wrn_q <= wrn_d;
      oe_q <= oe_d;
    end
endmodule

// File: tb/tb_cpld_uart_ctrl.sv
// tb_cpld_uart_ctrl: scoreboard bench with a behavioural CPLD model for cpld_uart_ctrl
module tb_cpld_uart_ctrl;
  localparam logic [31:0] A_DATA = 32'hBFD003F8;
  localparam logic [31:0] A_STAT = 32'hBFD003FC;
  localparam int SETUP = 1;
  localparam int PULSE = 3;
  localparam int K_RD = 0, K_WR = 1, K_ST = 2, K_NOP = 3;
  typedef struct {
    int kind;
    logic [31:0] exp;
  } txn_t;
  logic clk = 0, rst = 1, ce_i = 0, we_i = 0;
  logic [31:0] addr_i = 0, data_i = 0, data_o;
  logic [3:0] sel_i = 4'hF;
  logic stall_o, uart_sel_o, uart_data_oe, uart_rdn, uart_wrn;
  logic [7:0] uart_data_i, uart_data_o;
  logic uart_dataready = 0, uart_tbre = 1, uart_tsre = 1;
  txn_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  logic want_dr = 0, want_tbre = 1, want_tsre = 1, fix_delay = 0, done = 0;
  logic [7:0] rx_byte = 0;
  logic wrn_prev = 1, waiting = 0;
  int t0 = 0, d1 = 0, d2 = 0, t_tsre = 0, wr_count = 0;
  logic [7:0] wr_byte = 0;
  logic rst_prev = 0, wrn_prev_m = 1, hold = 0;
  int rdn_low = 0, wrn_low = 0, oe_setup = 0, stall_cnt = 0, n_wr = 0;
  txn_t t;

  cpld_uart_ctrl dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .sel_i(sel_i), .data_o(data_o), .stall_o(stall_o), .uart_sel_o(uart_sel_o),
    .uart_data_i(uart_data_i), .uart_data_o(uart_data_o), .uart_data_oe(uart_data_oe),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_dataready(uart_dataready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CPLD: presents rx_byte only while rdn is low, latches the TX byte on the wrn rising edge,
  // then drops tbre/tsre and raises them d1/d2 cycles later.
  assign uart_data_i = !uart_rdn ? rx_byte : ~rx_byte;
  always @(posedge clk) begin
    #1;
    if (!rst && !wrn_prev && uart_wrn) begin
      wr_byte = uart_data_o;
      wr_count++;
      waiting = 1;
      t0 = cyc;
      d1 = fix_delay ? 20 : int'($urandom_range(2, 12));
      d2 = d1 + (fix_delay ? 20 : int'($urandom_range(1, 12)));
      uart_tbre = 0;
      uart_tsre = 0;
    end else if (waiting && !rst) begin
      if (cyc == t0 + d1) uart_tbre = 1;
      if (cyc == t0 + d2) begin
        uart_tsre = 1;
        t_tsre = cyc;
        waiting = 0;
      end
    end else begin
      waiting = 0;
      uart_tbre = want_tbre;
      uart_tsre = want_tsre;
    end
    uart_dataready = want_dr;
    wrn_prev = uart_wrn;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop whenever the CPU side is released.
  always @(negedge clk) begin
    if (rst_prev && !ce_i)
      chk("reset_state", {uart_rdn, uart_wrn, uart_data_oe, stall_o, uart_sel_o, data_o},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    if (rst) begin
      rdn_low = 0; wrn_low = 0; oe_setup = 0; hold = 0; stall_cnt = 0;
    end else begin
      chk("strobe_exclusion", (!uart_rdn && !uart_wrn) || (uart_data_oe && !uart_rdn), 0);
      if (!uart_rdn) rdn_low++;
      else if (rdn_low != 0) begin
        chk("rdn_low_width", rdn_low, PULSE);
        rdn_low = 0;
      end
      if (!uart_wrn) begin
        if (wrn_prev_m) chk("wr_setup_oe_cycles", oe_setup, SETUP);
        wrn_low++;
      end else if (wrn_low != 0) begin
        chk("wrn_low_width", wrn_low, PULSE);
        chk("oe_hold_first", uart_data_oe, 1);
        hold = 1;
        wrn_low = 0;
      end else if (hold) begin
        chk("oe_hold_release", uart_data_oe, 0);
        hold = 0;
      end
      oe_setup = !uart_data_oe ? 0 : (uart_wrn ? oe_setup + 1 : oe_setup);
      if (ce_i && stall_o) begin
        stall_cnt++;
        if (stall_cnt == 400) chk("stall_timeout", stall_cnt, 0);
      end else if (ce_i) begin
        if (sb.size() == 0) chk("unexpected_accept", 1, 0);
        else begin
          t = sb.pop_front();
          case (t.kind)
            K_RD: begin
              chk("rd_data", data_o, t.exp);
              chk("rd_stall_cycles", stall_cnt, PULSE + 1);
              chk("rd_sel", uart_sel_o, 1);
            end
            K_WR: begin
              n_wr++;
              chk("wr_count", wr_count, n_wr);
              chk("wr_byte", wr_byte, t.exp);
              chk("wr_done_after_tsre", cyc, t_tsre + 3);
              chk("wr_sel", uart_sel_o, 1);
            end
            K_ST: begin
              chk("stat_data", data_o, t.exp);
              chk("stat_stall", stall_cnt, 0);
              chk("stat_sel", uart_sel_o, 0);
            end
            default: begin
              chk("nop_stall", stall_cnt, 0);
              chk("nop_sel", uart_sel_o, 0);
              chk("nop_strobes", {uart_rdn, uart_wrn}, 2'b11);
            end
          endcase
        end
        stall_cnt = 0;
      end else stall_cnt = 0;
    end
    rst_prev = rst;
    wrn_prev_m = uart_wrn;
    if (done) begin
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic issue(input int kind, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel, input logic [31:0] exp);
    txn_t n;
    n.kind = kind;
    n.exp = exp;
    sb.push_back(n);
    ce_i = 1; we_i = we; addr_i = addr; data_i = data; sel_i = sel;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!stall_o) break;
    end
    @(posedge clk); #1;
    ce_i = 0;
  endtask

  task automatic stat_read(input logic dr, input logic tb, input logic ts);
    want_dr = dr; want_tbre = tb; want_tsre = ts;
    repeat (4) @(posedge clk);
    #1;
    issue(K_ST, 0, A_STAT, $urandom, 4'hF, {30'b0, dr, tb && ts});
  endtask

  initial begin
    int k;
    logic [31:0] d, a;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    fix_delay = 1;
    issue(K_WR, 1, A_DATA, 32'hFFFFFF41, 4'b0001, 32'h41);
    fix_delay = 0;
    issue(K_WR, 1, A_DATA, 32'h00000041, 4'b1111, 32'h41);
    rx_byte = 8'h5A;
    issue(K_RD, 0, A_DATA, 32'h0, 4'hF, 32'h5A);
    stat_read(1, 1, 1);
    stat_read(0, 0, 1);
    stat_read(0, 1, 0);
    stat_read(1, 0, 1);
    issue(K_NOP, 0, 32'h80000000, 32'h0, 4'hF, 32'h0);
    issue(K_NOP, 1, 32'h80000000, 32'h55, 4'hF, 32'h0);
    issue(K_NOP, 1, A_STAT, 32'h77, 4'hF, 32'h0);
    issue(K_WR, 1, A_DATA, 32'h12345699, 4'hF, 32'h99);
    rx_byte = 8'hC3;
    issue(K_RD, 0, A_DATA, 32'h0, 4'hF, 32'hC3);
    ce_i = 1; we_i = 1; addr_i = A_DATA; data_i = 32'hAB;
    for (int i = 0; i < 50 && uart_wrn; i++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1; ce_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 4));
      d = $urandom;
      case (k)
        0: begin
          rx_byte = d[7:0];
          issue(K_RD, 0, A_DATA, 32'h0, 4'hF, {24'b0, d[7:0]});
        end
        1: issue(K_WR, 1, A_DATA, d, d[11:8], {24'b0, d[7:0]});
        2: stat_read(d[0], d[1], d[2]);
        3: issue(K_NOP, 1, A_STAT, d, 4'hF, 32'h0);
        default: begin
          a = $urandom;
          if (a == A_DATA || a == A_STAT) a = 32'h0;
          issue(K_NOP, d[0], a, d, 4'hF, 32'h0);
        end
      endcase
    end
    done = 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
